// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM states and byte select/merge helpers for the 4-line x 16-byte direct-mapped cache
package cache_pkg;
  localparam int ADDR_W = 10;
  localparam int LINE_W = 128;
  localparam int TAG_W = 4;
  localparam int IDX_W = 2;
  localparam int OFF_W = 4;
  localparam int NLINES = 4;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP} state_t;
  function automatic logic [7:0] byte_sel(input logic [LINE_W-1:0] line, input logic [OFF_W-1:0] off);
    return line[(LINE_W-8) - 8*int'(off) +: 8];
  endfunction
  function automatic logic [LINE_W-1:0] byte_merge(input logic [LINE_W-1:0] line, input logic [OFF_W-1:0] off, input logic [7:0] b);
    logic [LINE_W-1:0] r;
    r = line;
    r[(LINE_W-8) - 8*int'(off) +: 8] = b;
    return r;
  endfunction
endpackage

// File: rtl/cache_req_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (req, last -> grant index, any) starting after last
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int GW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic [GW-1:0]   grant,
  output logic            any
);
  int c;
  always_comb begin
    grant = last;
    any = 1'b0;
    c = 0;
    for (int i = NREQ; i >= 1; i--) begin
      c = (int'(last) + i) % NREQ;
      if (req[c]) begin
        grant = GW'(c);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cache_req_scheduler.sv
// cache_req_scheduler: arbitrates NREQ byte requesters onto a write-through write-allocate cache (req/we/addr/wdata -> ready/rdata/hit) backed by a 128-bit memory (mem_*), with hit/miss counters
module cache_req_scheduler
  import cache_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*8-1:0]      wdata,
  output logic [NREQ-1:0]        ready,
  output logic [7:0]             rdata,
  output logic                   hit,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   mem_ack,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt
);
  localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t state, state_n;
  logic [GW-1:0] grant, last_grant, arb_grant;
  logic arb_any;
  logic l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [7:0] l_wdata;
  logic hit_r;
  logic [NLINES-1:0] valid;
  logic [TAG_W-1:0] tags [NLINES];
  logic [LINE_W-1:0] data [NLINES];
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-1:0] off;
  logic lookup_hit;
  assign idx = l_addr[OFF_W +: IDX_W];
  assign tag = l_addr[ADDR_W-1 -: TAG_W];
  assign off = l_addr[OFF_W-1:0];
  assign lookup_hit = valid[idx] && tags[idx] == tag;
  rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
    .req(req),
    .last(last_grant),
    .grant(arb_grant),
    .any(arb_any)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = arb_any ? LOOKUP : IDLE;
      LOOKUP:  state_n = !lookup_hit ? REFILL : (l_we ? WRITE : RESP);
      REFILL:  state_n = !mem_ack ? REFILL : (l_we ? WRITE : RESP);
      WRITE:   state_n = mem_ack ? RESP : WRITE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs decode straight from state so an async reset drops mem_req at once.
  always_comb begin
    ready = NREQ'(state == RESP) << grant;
    rdata = (state == RESP && !l_we) ? byte_sel(data[idx], off) : 8'h0;
    hit = state == RESP && hit_r;
    mem_req = state == REFILL || state == WRITE;
    mem_we = state == WRITE;
    mem_addr = mem_req ? {l_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    mem_wdata = mem_we ? data[idx] : '0;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= GW'(NREQ-1);
      l_we <= 1'b0;
      l_addr <= '0;
      l_wdata <= '0;
      hit_r <= 1'b0;
      valid <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
      for (int i = 0; i < NLINES; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      state <= state_n;
      if (state == IDLE && arb_any) begin
        grant <= arb_grant;
        l_we <= we[arb_grant];
        l_addr <= addr[int'(arb_grant)*ADDR_W +: ADDR_W];
        l_wdata <= wdata[int'(arb_grant)*8 +: 8];
      end
      if (state == LOOKUP) begin
        hit_r <= lookup_hit;
        if (lookup_hit) hit_cnt <= hit_cnt + 1'b1;
        else miss_cnt <= miss_cnt + 1'b1;
        if (lookup_hit && l_we) data[idx] <= byte_merge(data[idx], off, l_wdata);
      end
      // A write miss merges its byte into the refill line as it lands.
      if (state == REFILL && mem_ack) begin
        data[idx] <= l_we ? byte_merge(mem_rdata, off, l_wdata) : mem_rdata;
        tags[idx] <= tag;
        valid[idx] <= 1'b1;
      end
      if (state == RESP) last_grant <= grant;
    end
  end
endmodule
